// File: rtl/axi_lite_tut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_tut_pkg
// Description : Shared types and constants for the AXI4-Lite mask-record
//               demonstration block (response codes, word offsets, master
//               state encoding, mask record layout).
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_tut_pkg;

   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_SLVERR  = 2'b10;

   // Word offsets inside one record
   localparam logic [1:0] c_WORD_CTRL  = 2'd0;
   localparam logic [1:0] c_WORD_OADDR = 2'd1;
   localparam logic [1:0] c_WORD_DATA  = 2'd2;
   localparam logic [1:0] c_WORD_LAST  = c_WORD_DATA;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_DONE    = 3'd5
   } master_state_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  n;
      logic [31:0] oaddr;
      logic [31:0] data;
   } mask_rec_t;

   // Bus image of one record word; word 3 is unused and reads as zero
   function automatic logic [31:0] rec_to_word(input mask_rec_t rec, input logic [1:0] word);
      logic [31:0] w;
      case (word)
         c_WORD_CTRL:  w = {rec.valid, 26'b0, rec.n};
         c_WORD_OADDR: w = rec.oaddr;
         c_WORD_DATA:  w = rec.data;
         default:      w = 32'h0;
      endcase
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_tut_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_tut_slave
// Description : Four-entry AXI4-Lite mask-record register slave. Entry index
//               is AXI address [5:4], word offset is [3:2]. Every accepted
//               write word is echoed on o_s_* for one cycle.
//               Optional: AXI_LITE_TUT_SLVERR_EN makes address bits [31:6]
//               nonzero answer SLVERR with no entry update and zero read data.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_tut_slave (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_awaddr,
   input  logic        i_awvalid,
   output logic        o_awready,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   input  logic        i_wvalid,
   output logic        o_wready,
   output logic [1:0]  o_bresp,
   output logic        o_bvalid,
   input  logic        i_bready,
   input  logic [31:0] i_araddr,
   input  logic        i_arvalid,
   output logic        o_arready,
   output logic [31:0] o_rdata,
   output logic [1:0]  o_rresp,
   output logic        o_rvalid,
   input  logic        i_rready,
   output logic        o_s_valid,
   output logic [31:0] o_s_addr,
   output logic [31:0] o_s_data
);
   import axi_lite_tut_pkg::*;

   mask_rec_t   r_entry [4];
   logic        r_wr_ready;
   logic        r_bvalid;
   logic [1:0]  r_bresp;
   logic        r_rd_ready;
   logic        r_rvalid;
   logic [1:0]  r_rresp;
   logic [31:0] r_rdata;
   logic        r_s_valid;
   logic [31:0] r_s_addr;
   logic [31:0] r_s_data;

   logic        w_wr_hs;
   logic        w_rd_hs;
   logic        w_aw_err;
   logic        w_ar_err;
   logic        w_unused_bits;
   logic [1:0]  w_wr_idx;
   logic [1:0]  w_wr_word;
   logic [31:0] w_wr_old;
   logic [31:0] w_wr_merged;
   logic [31:0] w_rd_word;

   assign w_wr_idx  = i_awaddr[5:4];
   assign w_wr_word = i_awaddr[3:2];
   assign w_wr_hs   = r_wr_ready & i_awvalid & i_wvalid;
   assign w_rd_hs   = r_rd_ready & i_arvalid;

`ifdef AXI_LITE_TUT_SLVERR_EN
   assign w_aw_err      = |i_awaddr[31:6];
   assign w_ar_err      = |i_araddr[31:6];
   assign w_unused_bits = ^{i_awaddr[1:0], i_araddr[1:0]};
`else
   assign w_aw_err      = 1'b0;
   assign w_ar_err      = 1'b0;
   assign w_unused_bits = ^{i_awaddr[31:6], i_awaddr[1:0], i_araddr[31:6], i_araddr[1:0]};
`endif

   // Byte-strobe merge of the incoming word onto the current entry image
   always_comb begin
      w_wr_old    = rec_to_word(r_entry[w_wr_idx], w_wr_word);
      w_wr_merged = w_wr_old;
      for (int b = 0; b < 4; b++) begin
         if (i_wstrb[b]) begin
            w_wr_merged[b*8 +: 8] = i_wdata[b*8 +: 8];
         end
      end
   end

   // Read word selection; an out-of-range address returns zero
   always_comb begin
      w_rd_word = 32'h0;
      if (!w_ar_err) begin
         w_rd_word = rec_to_word(r_entry[i_araddr[5:4]], i_araddr[3:2]);
      end
   end

   // Write channel: one-cycle AW/W ready, B response, entry update and echo
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ready <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_s_valid  <= 1'b0;
         r_s_addr   <= 32'h0;
         r_s_data   <= 32'h0;
         for (int e = 0; e < 4; e++) begin
            r_entry[e] <= '0;
         end
      end else begin
         r_s_valid  <= 1'b0;
         r_wr_ready <= !r_wr_ready && !r_bvalid && i_awvalid && i_wvalid;
         if (w_wr_hs) begin
            r_bvalid  <= 1'b1;
            r_bresp   <= w_aw_err ? RESP_SLVERR : RESP_OKAY;
            r_s_valid <= 1'b1;
            r_s_addr  <= i_awaddr;
            r_s_data  <= i_wdata;
            if (!w_aw_err) begin
               case (w_wr_word)
                  c_WORD_CTRL: begin
                     r_entry[w_wr_idx].valid <= w_wr_merged[31];
                     r_entry[w_wr_idx].n     <= w_wr_merged[4:0];
                  end
                  c_WORD_OADDR: r_entry[w_wr_idx].oaddr <= w_wr_merged;
                  c_WORD_DATA:  r_entry[w_wr_idx].data  <= w_wr_merged;
                  default: ;
               endcase
            end
         end else if (r_bvalid && i_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Read channel: ARREADY one cycle after ARVALID, then RVALID until RREADY
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ready <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rresp    <= RESP_OKAY;
         r_rdata    <= 32'h0;
      end else begin
         r_rd_ready <= !r_rd_ready && !r_rvalid && i_arvalid;
         if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
            r_rdata  <= w_rd_word;
         end else if (r_rvalid && i_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign o_awready = r_wr_ready;
   assign o_wready  = r_wr_ready;
   assign o_bvalid  = r_bvalid;
   assign o_bresp   = r_bresp;
   assign o_arready = r_rd_ready;
   assign o_rvalid  = r_rvalid;
   assign o_rresp   = r_rresp;
   assign o_rdata   = r_rdata;
   assign o_s_valid = r_s_valid;
   assign o_s_addr  = r_s_addr;
   assign o_s_data  = r_s_data;

endmodule
`default_nettype wire

// File: rtl/axi_lite_tut_core.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_tut_core
// Description : Command-driven AXI4-Lite master moving one mask record as
//               three words to/from the internal register slave.
//               Optional: AXI_LITE_TUT_SLVERR_EN (enables slave range check).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_tut_core (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        M_MASK_READ_WRITE_TRANSACTION,
   input  logic        M_MASK_START_TRANSACTION,
   input  logic [31:0] M_MASK_ADDR,
   input  logic        M_MASK_VALID,
   input  logic [4:0]  M_MASK_N,
   input  logic [31:0] M_MASK_OUTPUT_ADDR,
   input  logic [31:0] M_MASK_DATA,
   output logic        M_MASK_VALID_OUT,
   output logic [4:0]  M_MASK_N_OUT,
   output logic [31:0] M_MASK_OUTPUT_ADDR_OUT,
   output logic [31:0] M_MASK_DATA_OUT,
   output logic        M_WRITE_RESPONSE_ERROR,
   output logic        M_READY_RESPONSE_ERROR,
   output logic        S_MASK_VALID,
   output logic [31:0] S_MASK_ADDR,
   output logic [31:0] S_MASK_DATA
);
   import axi_lite_tut_pkg::*;

   master_state_t r_state;
   master_state_t w_state_nxt;

   logic        r_start_q;
   logic        r_start_qq;
   logic [27:0] r_cmd_base;
   mask_rec_t   r_cmd_rec;
   logic [1:0]  r_word;
   logic        r_stage_valid;
   logic [4:0]  r_stage_n;
   logic [31:0] r_stage_oaddr;
   logic        r_wr_err_acc;
   logic        r_rd_err_acc;
   logic        r_wr_err;
   logic        r_rd_err;
   mask_rec_t   r_out;

   logic        w_start_edge;
   logic        w_last;
   logic        w_unused_addr;
   logic [31:0] w_axaddr;
   logic [31:0] w_wdata;
   logic        w_awvalid;
   logic        w_wvalid;
   logic        w_bready;
   logic        w_arvalid;
   logic        w_rready;
   logic        w_awready;
   logic        w_wready;
   logic [1:0]  w_bresp;
   logic        w_bvalid;
   logic        w_arready;
   logic [31:0] w_rdata;
   logic [1:0]  w_rresp;
   logic        w_rvalid;
   logic        w_bresp_err;
   logic        w_rresp_err;

   assign w_start_edge  = r_start_q & ~r_start_qq;
   assign w_last        = (r_word == c_WORD_LAST);
   assign w_axaddr      = {r_cmd_base, r_word, 2'b00};
   assign w_wdata       = rec_to_word(r_cmd_rec, r_word);
   assign w_bresp_err   = (w_bresp != RESP_OKAY);
   assign w_rresp_err   = (w_rresp != RESP_OKAY);
   assign w_unused_addr = ^M_MASK_ADDR[1:0];

   // Two-stage sample of START for rising-edge detection
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_start_q  <= 1'b0;
         r_start_qq <= 1'b0;
      end else begin
         r_start_q  <= M_MASK_START_TRANSACTION;
         r_start_qq <= r_start_q;
      end
   end

   // Master state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Master next-state and AXI valid/ready decode
   always_comb begin
      w_state_nxt = r_state;
      w_awvalid   = 1'b0;
      w_wvalid    = 1'b0;
      w_bready    = 1'b0;
      w_arvalid   = 1'b0;
      w_rready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_edge) begin
               w_state_nxt = M_MASK_READ_WRITE_TRANSACTION ? ST_RD_REQ : ST_WR_REQ;
            end
         end
         ST_WR_REQ: begin
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
            if (w_awready && w_wready) begin
               w_state_nxt = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            w_bready = 1'b1;
            if (w_bvalid) begin
               w_state_nxt = w_last ? ST_DONE : ST_WR_REQ;
            end
         end
         ST_RD_REQ: begin
            w_arvalid = 1'b1;
            if (w_arready) begin
               w_state_nxt = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            w_rready = 1'b1;
            if (w_rvalid) begin
               w_state_nxt = w_last ? ST_DONE : ST_RD_REQ;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Command capture, word counter, error tracking and read-back assembly.
   // The AXI address carries record ADDR[31:4] above the entry/word bits;
   // ADDR[31:29] fold into one bit so any nonzero upper address stays
   // nonzero on the bus.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_cmd_base    <= 28'h0;
         r_cmd_rec     <= '0;
         r_word        <= c_WORD_CTRL;
         r_stage_valid <= 1'b0;
         r_stage_n     <= 5'h0;
         r_stage_oaddr <= 32'h0;
         r_wr_err_acc  <= 1'b0;
         r_rd_err_acc  <= 1'b0;
         r_wr_err      <= 1'b0;
         r_rd_err      <= 1'b0;
         r_out         <= '0;
      end else begin
         if (r_state == ST_IDLE && w_start_edge) begin
            r_cmd_base      <= {|M_MASK_ADDR[31:29], M_MASK_ADDR[28:2]};
            r_cmd_rec.valid <= M_MASK_VALID;
            r_cmd_rec.n     <= M_MASK_N;
            r_cmd_rec.oaddr <= M_MASK_OUTPUT_ADDR;
            r_cmd_rec.data  <= M_MASK_DATA;
            r_word          <= c_WORD_CTRL;
            if (M_MASK_READ_WRITE_TRANSACTION) begin
               r_rd_err_acc <= 1'b0;
               r_rd_err     <= 1'b0;
            end else begin
               r_wr_err_acc <= 1'b0;
               r_wr_err     <= 1'b0;
            end
         end
         if (r_state == ST_WR_RESP && w_bvalid) begin
            r_word <= r_word + 2'd1;
            if (w_last) begin
               r_wr_err <= r_wr_err_acc | w_bresp_err;
            end else begin
               r_wr_err_acc <= r_wr_err_acc | w_bresp_err;
            end
         end
         if (r_state == ST_RD_DATA && w_rvalid) begin
            r_word <= r_word + 2'd1;
            if (r_word == c_WORD_CTRL) begin
               r_stage_valid <= w_rdata[31];
               r_stage_n     <= w_rdata[4:0];
            end
            if (r_word == c_WORD_OADDR) begin
               r_stage_oaddr <= w_rdata;
            end
            if (w_last) begin
               r_out.valid <= r_stage_valid;
               r_out.n     <= r_stage_n;
               r_out.oaddr <= r_stage_oaddr;
               r_out.data  <= w_rdata;
               r_rd_err    <= r_rd_err_acc | w_rresp_err;
            end else begin
               r_rd_err_acc <= r_rd_err_acc | w_rresp_err;
            end
         end
      end
   end

   axi_lite_tut_slave u_slave (
      .clk       (aclk),
      .rst_n     (aresetn),
      .i_awaddr  (w_axaddr),
      .i_awvalid (w_awvalid),
      .o_awready (w_awready),
      .i_wdata   (w_wdata),
      .i_wstrb   (4'hF),
      .i_wvalid  (w_wvalid),
      .o_wready  (w_wready),
      .o_bresp   (w_bresp),
      .o_bvalid  (w_bvalid),
      .i_bready  (w_bready),
      .i_araddr  (w_axaddr),
      .i_arvalid (w_arvalid),
      .o_arready (w_arready),
      .o_rdata   (w_rdata),
      .o_rresp   (w_rresp),
      .o_rvalid  (w_rvalid),
      .i_rready  (w_rready),
      .o_s_valid (S_MASK_VALID),
      .o_s_addr  (S_MASK_ADDR),
      .o_s_data  (S_MASK_DATA)
   );

   assign M_MASK_VALID_OUT       = r_out.valid;
   assign M_MASK_N_OUT           = r_out.n;
   assign M_MASK_OUTPUT_ADDR_OUT = r_out.oaddr;
   assign M_MASK_DATA_OUT        = r_out.data;
   assign M_WRITE_RESPONSE_ERROR = r_wr_err;
   assign M_READY_RESPONSE_ERROR = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_tut_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_tut_core
// Description : Self-checking bench for axi_lite_tut_core: directed vector
//               table, busy/reset sequences and randomized transactions
//               against a record-level reference model.
//               AXI_LITE_TUT_SLVERR_EN adds the out-of-range address checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_tut_core;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        rw = 1'b0;
   logic        start = 1'b0;
   logic [31:0] addr = 32'h0;
   logic        fvalid = 1'b0;
   logic [4:0]  fn = 5'h0;
   logic [31:0] foaddr = 32'h0;
   logic [31:0] fdata = 32'h0;
   logic        valid_out;
   logic [4:0]  n_out;
   logic [31:0] oaddr_out;
   logic [31:0] data_out;
   logic        wr_err;
   logic        rd_err;
   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_data;

   axi_lite_tut_core dut (
      .aclk                          (aclk),
      .aresetn                       (aresetn),
      .M_MASK_READ_WRITE_TRANSACTION (rw),
      .M_MASK_START_TRANSACTION      (start),
      .M_MASK_ADDR                   (addr),
      .M_MASK_VALID                  (fvalid),
      .M_MASK_N                      (fn),
      .M_MASK_OUTPUT_ADDR            (foaddr),
      .M_MASK_DATA                   (fdata),
      .M_MASK_VALID_OUT              (valid_out),
      .M_MASK_N_OUT                  (n_out),
      .M_MASK_OUTPUT_ADDR_OUT        (oaddr_out),
      .M_MASK_DATA_OUT               (data_out),
      .M_WRITE_RESPONSE_ERROR        (wr_err),
      .M_READY_RESPONSE_ERROR        (rd_err),
      .S_MASK_VALID                  (s_valid),
      .S_MASK_ADDR                   (s_addr),
      .S_MASK_DATA                   (s_data)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      bit        valid;
      bit [4:0]  n;
      bit [31:0] oaddr;
      bit [31:0] data;
   } rec_t;

   typedef struct {
      bit        rw;
      bit [31:0] addr;
      bit        v;
      bit [4:0]  n;
      bit [31:0] oa;
      bit [31:0] d;
      int        hold;
      bit        reedge;
      rec_t      exp;
   } vec_t;

   rec_t mem [4];
   rec_t exp_out;
   bit   exp_wr_err;
   bit   exp_rd_err;
   int   n_vec = 0;
   int   n_err = 0;
   vec_t tab [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit addr_bad(input bit [31:0] a);
`ifdef AXI_LITE_TUT_SLVERR_EN
      return |a[31:4];
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit [31:0] word_of(input rec_t r, input int w);
      case (w)
         0:       return {r.valid, 26'b0, r.n};
         1:       return r.oaddr;
         2:       return r.data;
         default: return 32'h0;
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".valid_out"}, {31'b0, valid_out}, {31'b0, exp_out.valid});
      check({tag, ".n_out"},     {27'b0, n_out},     {27'b0, exp_out.n});
      check({tag, ".oaddr_out"}, oaddr_out,          exp_out.oaddr);
      check({tag, ".data_out"},  data_out,           exp_out.data);
      check({tag, ".wr_err"},    {31'b0, wr_err},    {31'b0, exp_wr_err});
      check({tag, ".rd_err"},    {31'b0, rd_err},    {31'b0, exp_rd_err});
   endtask

   task automatic model_reset();
      for (int e = 0; e < 4; e++) mem[e] = '{1'b0, 5'd0, 32'h0, 32'h0};
      exp_out    = '{1'b0, 5'd0, 32'h0, 32'h0};
      exp_wr_err = 1'b0;
      exp_rd_err = 1'b0;
   endtask

   // One complete transaction observed over 16 cycles; cycle i of the loop is S+i
   task automatic do_txn(input bit t_rw, input bit [31:0] t_addr, input bit t_v, input bit [4:0] t_n,
                         input bit [31:0] t_oa, input bit [31:0] t_d, input int hold, input bit reedge,
                         input bit use_tab, input rec_t tab_exp);
      rec_t fields;
      rec_t rd_exp;
      bit   bad;
      int   idx;
      bit   pulse_exp;
      int   w;
      fields = '{t_v, t_n, t_oa, t_d};
      bad    = addr_bad(t_addr);
      idx    = int'(t_addr[3:2]);
      rd_exp = bad ? '{1'b0, 5'd0, 32'h0, 32'h0} : mem[idx];
      if (use_tab) rd_exp = tab_exp;
      rw = t_rw; addr = t_addr; fvalid = t_v; fn = t_n; foaddr = t_oa; fdata = t_d;
      start = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge aclk); #1;
         start = (i + 1 < hold) || (reedge && (i == 4 || i == 5));
         if (i == 1) begin
            rw = $urandom_range(0, 1); addr = $urandom; fvalid = $urandom_range(0, 1);
            fn = 5'($urandom); foaddr = $urandom; fdata = $urandom;
         end
         pulse_exp = !t_rw && (i == 3 || i == 6 || i == 9);
         check($sformatf("s_valid@S+%0d", i), {31'b0, s_valid}, {31'b0, pulse_exp});
         if (pulse_exp && s_valid) begin
            w = i / 3 - 1;
            if (t_addr[31:4] == 28'h0) check("s_addr", s_addr, 32'(idx * 16 + w * 4));
            check("s_data", s_data, word_of(fields, w));
         end
         if (i == 1) begin
            if (t_rw) check("rd_err_clear", {31'b0, rd_err}, 32'h0);
            else      check("wr_err_clear", {31'b0, wr_err}, 32'h0);
         end
         if (i == 9 && t_rw) check_outputs("hold@S+9");
         if (i == 10) begin
            if (t_rw) begin
               exp_out    = rd_exp;
               exp_rd_err = bad;
            end else begin
               exp_wr_err = bad;
               if (!bad) mem[idx] = fields;
            end
            check_outputs(t_rw ? "read@S+10" : "write@S+10");
         end
      end
      start = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".valid_out"}, {31'b0, valid_out}, 32'h0);
      check({tag, ".n_out"},     {27'b0, n_out},     32'h0);
      check({tag, ".oaddr_out"}, oaddr_out,          32'h0);
      check({tag, ".data_out"},  data_out,           32'h0);
      check({tag, ".wr_err"},    {31'b0, wr_err},    32'h0);
      check({tag, ".rd_err"},    {31'b0, rd_err},    32'h0);
      check({tag, ".s_valid"},   {31'b0, s_valid},   32'h0);
      check({tag, ".s_addr"},    s_addr,             32'h0);
      check({tag, ".s_data"},    s_data,             32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1);
   end

   initial begin
      rec_t z;
      rec_t full;
      z    = '{1'b0, 5'd0, 32'h0, 32'h0};
      full = '{1'b1, 5'd3, 32'h4, 32'hFFFF_FFFF};
      tab[0]  = '{1'b1, 32'h0, 1'b0, 5'd0,  32'h0,         32'h0,         1,  1'b0, z};
      tab[1]  = '{1'b0, 32'h0, 1'b1, 5'd3,  32'h4,         32'hFFFF_FFFF, 1,  1'b0, z};
      tab[2]  = '{1'b1, 32'h0, 1'b0, 5'd0,  32'h0,         32'h0,         1,  1'b0, full};
      tab[3]  = '{1'b0, 32'h4, 1'b1, 5'd3,  32'h4,         32'hFFFF_FFFF, 1,  1'b0, z};
      tab[4]  = '{1'b0, 32'h8, 1'b1, 5'd3,  32'h4,         32'hFFFF_FFFF, 2,  1'b0, z};
      tab[5]  = '{1'b0, 32'hC, 1'b1, 5'd3,  32'h4,         32'hFFFF_FFFF, 3,  1'b0, z};
      tab[6]  = '{1'b1, 32'h4, 1'b0, 5'd0,  32'h0,         32'h0,         1,  1'b0, full};
      tab[7]  = '{1'b1, 32'h8, 1'b0, 5'd0,  32'h0,         32'h0,         1,  1'b0, full};
      tab[8]  = '{1'b1, 32'hC, 1'b0, 5'd0,  32'h0,         32'h0,         1,  1'b0, full};
      tab[9]  = '{1'b0, 32'hC, 1'b0, 5'd3,  32'h4,         32'hFFFF_FFFF, 1,  1'b0, z};
      tab[10] = '{1'b1, 32'hC, 1'b0, 5'd0,  32'h0,         32'h0,         1,  1'b0,
                  '{1'b0, 5'd3, 32'h4, 32'hFFFF_FFFF}};
      tab[11] = '{1'b0, 32'h8, 1'b0, 5'd31, 32'h1234_5678, 32'hA5A5_A5A5, 10, 1'b0, z};
      tab[12] = '{1'b0, 32'h4, 1'b1, 5'd21, 32'hDEAD_0000, 32'h0BAD_F00D, 2,  1'b1, z};
      tab[13] = '{1'b1, 32'h8, 1'b0, 5'd0,  32'h0,         32'h0,         1,  1'b0,
                  '{1'b0, 5'd31, 32'h1234_5678, 32'hA5A5_A5A5}};
      tab[14] = '{1'b1, 32'h4, 1'b0, 5'd0,  32'h0,         32'h0,         1,  1'b1,
                  '{1'b1, 5'd21, 32'hDEAD_0000, 32'h0BAD_F00D}};
      tab[15] = '{1'b1, 32'h0, 1'b0, 5'd0,  32'h0,         32'h0,         10, 1'b0, full};

      model_reset();
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      check_reset_state("in_reset");
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      check_reset_state("after_reset");

      for (int v = 0; v < 16; v++) begin
         do_txn(tab[v].rw, tab[v].addr, tab[v].v, tab[v].n, tab[v].oa, tab[v].d,
                tab[v].hold, tab[v].reedge, tab[v].rw, tab[v].exp);
      end

      // Reset in the middle of a write: everything returns to zero at once
      rw = 1'b0; addr = 32'h8; fvalid = 1'b1; fn = 5'd9; foaddr = 32'h55; fdata = 32'h66;
      start = 1'b1;
      repeat (6) @(posedge aclk);
      #1;
      start = 1'b0;
      aresetn = 1'b0;
      #2;
      check_reset_state("mid_reset");
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      model_reset();
      @(posedge aclk); #1;
      do_txn(1'b1, 32'h8, 1'b0, 5'd0, 32'h0, 32'h0, 1, 1'b0, 1'b1, '{1'b0, 5'd0, 32'h0, 32'h0});

      // Randomized transactions against the record model
      for (int r = 0; r < 30; r++) begin
         do_txn(1'($urandom_range(0, 1)), $urandom & 32'hF, 1'($urandom_range(0, 1)), 5'($urandom),
                $urandom, $urandom, $urandom_range(1, 4), 1'b0, 1'b0, '{1'b0, 5'd0, 32'h0, 32'h0});
      end

`ifdef AXI_LITE_TUT_SLVERR_EN
      do_txn(1'b0, 32'h0, 1'b1, 5'd7, 32'hCAFE_0000, 32'h1111_2222, 1, 1'b0, 1'b0, '{1'b0, 5'd0, 32'h0, 32'h0});
      do_txn(1'b0, 32'h10, 1'b1, 5'd3, 32'h4, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, '{1'b0, 5'd0, 32'h0, 32'h0});
      check("slverr_wr_flag", {31'b0, wr_err}, 32'h1);
      do_txn(1'b1, 32'h10, 1'b0, 5'd0, 32'h0, 32'h0, 1, 1'b0, 1'b0, '{1'b0, 5'd0, 32'h0, 32'h0});
      check("slverr_rd_flag", {31'b0, rd_err}, 32'h1);
      do_txn(1'b1, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1, 1'b0, 1'b1,
             '{1'b1, 5'd7, 32'hCAFE_0000, 32'h1111_2222});
      check("slverr_rd_cleared", {31'b0, rd_err}, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
